// File: rtl/kyber_parse_sampler.sv
// Kyber Parse: rejection-samples 12-bit candidates from 3-byte XOF chunks and
// packs accepted coefficients CPW per word into the polynomial RAM.
module kyber_parse_sampler #(
    parameter int Q      = 3329,
    parameter int COEF_W = 12,
    parameter int N      = 256,
    parameter int CPW    = 8,
    parameter int ADDR_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic                    in_valid,
    input  logic [23:0]             in_data,
    output logic                    in_ready,
    output logic                    enw,
    output logic [ADDR_W-1:0]       waddr,
    output logic [CPW*COEF_W-1:0]   dout,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             rej_cnt
);

    localparam int CW = $clog2(N + 1);
    localparam int FW = $clog2(CPW + 1);
    localparam int DW = CPW * COEF_W;
    localparam logic [CW-1:0]     N_C   = CW'(N);
    localparam logic [CW-1:0]     NM1_C = CW'(N - 1);
    localparam logic [FW-1:0]     CPW_C = FW'(CPW);
    localparam logic [COEF_W-1:0] Q_C   = COEF_W'(Q);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [FW-1:0]       fill_q, fill_d;
    logic [CW-1:0]       coef_cnt_q, coef_cnt_d;
    logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
    logic [15:0]         rej_q, rej_d;
    logic [DW-1:0]       buf_q, buf_d;
    logic                enw_q, enw_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DW-1:0]       dout_q, dout_d;

    logic [COEF_W-1:0]   d1, d2;
    logic                acc1, acc2, keep2, hs, word_done;
    logic [1:0]          rej_inc;
    logic [16:0]         rej_sum;
    logic [DW-1:0]       word_v;

    // d1 = b0 + 256*(b1 & 0xF) and d2 = (b1 >> 4) + 16*b2 are plain bit fields.
    assign d1 = COEF_W'(in_data[11:0]);
    assign d2 = COEF_W'(in_data[23:12]);

    assign in_ready = (state_q == S_RUN) && (coef_cnt_q < N_C);
    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign enw      = enw_q;
    assign waddr    = waddr_q;
    assign dout     = dout_q;
    assign rej_cnt  = rej_q;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        fill_d     = fill_q;
        coef_cnt_d = coef_cnt_q;
        word_idx_d = word_idx_q;
        rej_d      = rej_q;
        buf_d      = buf_q;
        enw_d      = 1'b0;
        waddr_d    = waddr_q;
        dout_d     = dout_q;
        word_done  = 1'b0;
        word_v     = '0;

        acc1    = (d1 < Q_C);
        acc2    = (d2 < Q_C);
        // The last slot only has room for d1; a dropped d2 is not a rejection.
        keep2   = acc2 && !(acc1 && (coef_cnt_q == NM1_C));
        hs      = in_valid && in_ready;
        rej_inc = {1'b0, ~acc1} + {1'b0, ~acc2};
        rej_sum = {1'b0, rej_q} + 17'(rej_inc);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_RUN;
                    base_d     = base_addr;
                    fill_d     = '0;
                    coef_cnt_d = '0;
                    word_idx_d = '0;
                    rej_d      = '0;
                    buf_d      = '0;
                end
            end
            S_RUN: begin
                // The final word's write pulse is visible for one cycle before DONE.
                if (enw_q && (coef_cnt_q == N_C)) begin
                    state_d = S_DONE;
                end
                if (hs) begin
                    if (acc1) begin
                        buf_d[fill_d*COEF_W +: COEF_W] = d1;
                        fill_d = fill_d + FW'(1);
                        if (fill_d == CPW_C) begin
                            word_done = 1'b1;
                            word_v    = buf_d;
                            fill_d    = '0;
                        end
                    end
                    if (keep2) begin
                        buf_d[fill_d*COEF_W +: COEF_W] = d2;
                        fill_d = fill_d + FW'(1);
                        if (fill_d == CPW_C) begin
                            word_done = 1'b1;
                            word_v    = buf_d;
                            fill_d    = '0;
                        end
                    end
                    coef_cnt_d = coef_cnt_q + CW'(acc1) + CW'(keep2);
                    rej_d      = rej_sum[16] ? 16'hFFFF : rej_sum[15:0];
                end
                if (word_done) begin
                    enw_d      = 1'b1;
                    waddr_d    = base_q + word_idx_q;
                    dout_d     = word_v;
                    word_idx_d = word_idx_q + ADDR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            fill_q     <= '0;
            coef_cnt_q <= '0;
            word_idx_q <= '0;
            rej_q      <= '0;
            buf_q      <= '0;
            enw_q      <= 1'b0;
            waddr_q    <= '0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            fill_q     <= fill_d;
            coef_cnt_q <= coef_cnt_d;
            word_idx_q <= word_idx_d;
            rej_q      <= rej_d;
            buf_q      <= buf_d;
            enw_q      <= enw_d;
            waddr_q    <= waddr_d;
            dout_q     <= dout_d;
        end
    end

endmodule

// File: tb/tb_kyber_parse_sampler.sv
// Bench for kyber_parse_sampler: table-driven polynomial runs plus hand-written
// corner sequences, all writes checked against a coefficient-list reference model.
module tb_kyber_parse_sampler;

    localparam int Q      = 3329;
    localparam int COEF_W = 12;
    localparam int N      = 256;
    localparam int CPW    = 8;
    localparam int ADDR_W = 8;
    localparam int DW     = CPW * COEF_W;
    localparam int NWORDS = N / CPW;

    logic              clk, rst, start, in_valid, in_ready, enw, busy, done;
    logic [ADDR_W-1:0] base_addr, waddr;
    logic [23:0]       in_data;
    logic [DW-1:0]     dout;
    logic [15:0]       rej_cnt;

    kyber_parse_sampler #(
        .Q(Q), .COEF_W(COEF_W), .N(N), .CPW(CPW), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .enw(enw), .waddr(waddr), .dout(dout), .busy(busy), .done(done),
        .rej_cnt(rej_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [ADDR_W+DW-1:0] exp_q[$];
    logic [23:0]          chunk_q[$];
    logic [DW-1:0]        wr_data[$];
    logic [ADDR_W-1:0]    wr_addr[$];
    int exp_rej, exp_hs, hs_cnt;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write pulse must match the head of the expected queue.
    logic [ADDR_W+DW-1:0] mon_e;
    always @(negedge clk) begin
        if (enw === 1'b1) begin
            wr_data.push_back(dout);
            wr_addr.push_back(waddr);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", waddr, dout);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", waddr, mon_e[ADDR_W+DW-1:DW]);
                check("write_data", dout, mon_e[DW-1:0]);
            end
        end
    end

    // Reference model: accept list of coefficients, then pack into words.
    function automatic void build_model(input logic [ADDR_W-1:0] base);
        int coefs[$];
        int c1, c2;
        logic [23:0] ch;
        logic [DW-1:0] word;
        logic [ADDR_W-1:0] a;
        exp_rej = 0;
        exp_hs  = 0;
        exp_q.delete();
        foreach (chunk_q[i]) begin
            if (coefs.size() >= N) break;
            ch = chunk_q[i];
            c1 = ch[7:0] + 256 * (ch[15:8] & 8'h0F);
            c2 = (ch[15:8] >> 4) + 16 * ch[23:16];
            exp_hs++;
            if (c1 < Q) coefs.push_back(c1);
            else exp_rej++;
            if (c2 < Q) begin
                if (coefs.size() < N) coefs.push_back(c2);
            end else exp_rej++;
        end
        if (coefs.size() < N) return;
        for (int w = 0; w < NWORDS; w++) begin
            word = '0;
            for (int k = 0; k < CPW; k++) word[k*COEF_W +: COEF_W] = COEF_W'(coefs[w*CPW + k]);
            a = base + ADDR_W'(w);
            exp_q.push_back({a, word});
        end
    endfunction

    function automatic logic [DW-1:0] wd(input int i);
        if (i < wr_data.size()) return wr_data[i];
        return 'x;
    endfunction

    function automatic logic [ADDR_W-1:0] wa(input int i);
        if (i < wr_addr.size()) return wr_addr[i];
        return 'x;
    endfunction

    task automatic run_poly(input logic [ADDR_W-1:0] base, input int gap_pct,
                            input int poke_at, input int abort_at);
        int idx, cycles;
        logic hs;
        bit poked;
        build_model(base);
        wr_data.delete();
        wr_addr.delete();
        hs_cnt = 0;
        idx    = 0;
        cycles = 0;
        poked  = 0;
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = base;
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = 8'h55;
        while (cycles < 20000) begin
            if (done === 1'b1) break;
            if (abort_at > 0 && hs_cnt == abort_at) break;
            start = 1'b0;
            if (poke_at >= 0 && hs_cnt == poke_at && !poked) begin
                start = 1'b1;
                base_addr = 8'hAA;
                poked = 1;
            end
            in_valid = (idx < chunk_q.size()) && ($urandom_range(99) >= gap_pct);
            in_data  = in_valid ? chunk_q[idx] : 24'($urandom);
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            if (hs) begin
                idx++;
                hs_cnt++;
            end
            cycles++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        if (abort_at > 0) begin
            exp_q.delete();
            rst = 1'b1;
            #1;
            check("rst_outputs", {enw, waddr, dout, busy, done, rej_cnt, in_ready}, '0);
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            check("post_rst_outputs", {enw, waddr, dout, busy, done, rej_cnt, in_ready}, '0);
            return;
        end
        check("timeout", cycles < 20000, 1'b1);
        check("done", done, 1'b1);
        check("busy_after_done", busy, 1'b0);
        check("in_ready_after_done", in_ready, 1'b0);
        check("rej_cnt", rej_cnt, exp_rej);
        check("handshakes", hs_cnt, exp_hs);
        check("missing_writes", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        check("done_held", done, 1'b1);
        check("write_count", wr_data.size(), NWORDS);
    endtask

    typedef struct {
        logic [ADDR_W-1:0] base;
        logic [23:0]       ca;
        logic [23:0]       cb;
        int                exp_rej;
        int                exp_hs;
        logic [DW-1:0]     exp_w0;
        int                poke;
    } vec_t;

    vec_t vecs[3];
    logic [DW-1:0] saved[$];

    initial begin
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        in_valid = 1'b0;
        in_data = '0;
        #1;
        check("reset_outputs", {enw, waddr, dout, busy, done, rej_cnt, in_ready}, '0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        vecs[0] = '{8'h10, 24'h0D0001, 24'h0D0001, 0,   128, {4{24'h0D0001}}, 10};
        vecs[1] = '{8'h80, 24'hFFFFFF, 24'h000000, 256, 256, '0, -1};
        vecs[2] = '{8'h00, 24'hFFF001, 24'hFFF001, 256, 256, {8{12'h001}}, -1};

        for (int v = 0; v < 3; v++) begin
            chunk_q.delete();
            for (int i = 0; i < 600; i++) chunk_q.push_back((i % 2 == 0) ? vecs[v].ca : vecs[v].cb);
            run_poly(vecs[v].base, 0, vecs[v].poke, -1);
            check("vec_rej", rej_cnt, vecs[v].exp_rej);
            check("vec_hs", hs_cnt, vecs[v].exp_hs);
            check("vec_word0", wd(0), vecs[v].exp_w0);
            check("vec_addr0", wa(0), vecs[v].base);
            check("vec_addr_last", wa(NWORDS-1), vecs[v].base + ADDR_W'(NWORDS-1));
        end

        // Straddle: fill reaches 7, then a two-accept chunk splits across words.
        chunk_q.delete();
        repeat (7) chunk_q.push_back(24'hFFF001);
        repeat (300) chunk_q.push_back(24'h0D0001);
        run_poly(8'h20, 0, -1, -1);
        check("straddle_word0", wd(0), {8{12'h001}});
        check("straddle_word1_slot0", wd(1) & DW'(12'hFFF), DW'(12'd208));

        // Final-coefficient drop at coef_cnt = 255.
        chunk_q.delete();
        repeat (127) chunk_q.push_back(24'h0D0001);
        chunk_q.push_back(24'hFFF001);
        repeat (10) chunk_q.push_back(24'h0D0001);
        run_poly(8'h05, 0, -1, -1);
        check("drop_rej", rej_cnt, 16'd1);
        check("drop_hs", hs_cnt, 129);
        check("drop_last_word", wd(NWORDS-1), 96'h0010010D00010D00010D0001);

        // Random chunks with gaps and address wrap, then the same stream gap-free.
        chunk_q.delete();
        for (int i = 0; i < 450; i++) chunk_q.push_back(24'($urandom));
        run_poly(8'hF0, 40, -1, -1);
        check("wrap_addr0", wa(0), 8'hF0);
        check("wrap_addr15", wa(15), 8'hFF);
        check("wrap_addr16", wa(16), 8'h00);
        check("wrap_addr31", wa(31), 8'h0F);
        saved = wr_data;
        run_poly(8'hF0, 0, -1, -1);
        for (int i = 0; i < NWORDS; i++) check("gap_vs_nogap", wd(i), (i < saved.size()) ? saved[i] : 'x);

        // Reset after 100 coefficients, then a clean run at a new base.
        chunk_q.delete();
        repeat (300) chunk_q.push_back(24'h0D0001);
        run_poly(8'h30, 0, -1, 50);
        run_poly(8'h40, 0, -1, -1);
        check("after_rst_addr0", wa(0), 8'h40);
        check("after_rst_word0", wd(0), {4{24'h0D0001}});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
